// File: rtl/wbuf_pkg.sv
// Weight buffer scheduler shared types and defaults.
// State encoding, default widths and beats-per-row derivation.
package wbuf_pkg;

  localparam int ADDR_LEN_D     = 16;
  localparam int DATA_LEN_D     = 64;
  localparam int DDR_DATA_LEN_D = 256;
  localparam int BUFFER_NUM_D   = 32;
  localparam int KSET_ROWS_D    = 9;

  // DDR beats needed to fill one buffer row across all banks
  function automatic int grp_num(input int bn, input int ddr_w,
                                 input int data_w);
    return bn / (ddr_w / data_w);
  endfunction

  localparam int GRP_NUM =
    grp_num(BUFFER_NUM_D, DDR_DATA_LEN_D, DATA_LEN_D);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/wsched_wr_seq.sv
// Weight load sequencer: beat/row counting and bank write-enable decode.
// Each accepted DDR beat becomes one registered buffer write.
module wsched_wr_seq
  import wbuf_pkg::*;
#(
  parameter int ADDR_LEN     = ADDR_LEN_D,
  parameter int DATA_LEN     = DATA_LEN_D,
  parameter int DDR_DATA_LEN = DDR_DATA_LEN_D,
  parameter int BUFFER_NUM   = BUFFER_NUM_D
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    active,
  input  logic [ADDR_LEN-1:0]     base_addr,
  input  logic [ADDR_LEN-1:0]     num_rows,
  input  logic [DDR_DATA_LEN-1:0] ddr_data,
  input  logic                    ddr_valid,
  output logic                    ddr_ready,
  output logic [DDR_DATA_LEN-1:0] data_wr,
  output logic [ADDR_LEN-1:0]     wr_addr,
  output logic [BUFFER_NUM-1:0]   wr_en,
  output logic                    fin
);

  localparam int GRP   = grp_num(BUFFER_NUM, DDR_DATA_LEN, DATA_LEN);
  localparam int LANES = BUFFER_NUM / GRP;
  localparam int BW    = (GRP > 1) ? $clog2(GRP) : 1;
  localparam logic [BW-1:0] LAST = BW'(GRP - 1);

  logic [BW-1:0]         beat;
  logic [ADDR_LEN-1:0]   row;
  logic [ADDR_LEN-1:0]   row_addr;
  logic [BUFFER_NUM-1:0] lane_mask;
  logic                  fire;

  // stop accepting once the final beat of the final row is in
  assign ddr_ready = active && !fin;
  assign fire      = ddr_valid && ddr_ready;

  // bank group selected by the current beat
  always_comb begin
    lane_mask = '0;
    lane_mask[LANES-1:0] = '1;
    lane_mask = lane_mask << (int'(beat) * LANES);
  end

  // registered write port, enables only in the cycle after a transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= '0;
      data_wr <= '0;
      wr_addr <= '0;
    end else begin
      wr_en <= fire ? lane_mask : '0;
      if (fire) begin
        data_wr <= ddr_data;
        wr_addr <= row_addr;
      end
    end
  end

  // beat and row position within the current load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat     <= '0;
      row      <= '0;
      row_addr <= '0;
      fin      <= 1'b0;
    end else if (clear) begin
      beat     <= '0;
      row      <= '0;
      row_addr <= base_addr;
      fin      <= 1'b0;
    end else if (fire) begin
      if (beat == LAST) begin
        beat     <= '0;
        row      <= row + ADDR_LEN'(1);
        row_addr <= row_addr + ADDR_LEN'(1);
        if (row == num_rows - ADDR_LEN'(1))
          fin <= 1'b1;
      end else begin
        beat <= beat + BW'(1);
      end
    end
  end

endmodule

// File: rtl/weight_buf_sched.sv
// Weight buffer scheduler: loads weight rows from DDR, then launches kernel-set reads.
// Optional stall counters are built when WSCHED_PERF_CNT_EN is defined.
module weight_buf_sched
  import wbuf_pkg::*;
#(
  parameter int ADDR_LEN     = ADDR_LEN_D,
  parameter int DATA_LEN     = DATA_LEN_D,
  parameter int DDR_DATA_LEN = DDR_DATA_LEN_D,
  parameter int BUFFER_NUM   = BUFFER_NUM_D,
  parameter int KSET_ROWS    = KSET_ROWS_D
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_LEN-1:0]     base_addr,
  input  logic [ADDR_LEN-1:0]     num_rows,
  input  logic [ADDR_LEN-1:0]     num_kset,
  input  logic [DDR_DATA_LEN-1:0] ddr_data,
  input  logic                    ddr_valid,
  output logic                    ddr_ready,
  output logic [DDR_DATA_LEN-1:0] data_wr,
  output logic [ADDR_LEN-1:0]     wr_addr,
  output logic [BUFFER_NUM-1:0]   wr_en,
  output logic                    rd_conf,
  output logic [ADDR_LEN-1:0]     st_rd_addr,
  input  logic                    buf_idle,
  input  logic                    ker_en,
  input  logic                    kset_ready,
  output logic                    busy,
  output logic                    done
`ifdef WSCHED_PERF_CNT_EN
  ,
  output logic [31:0]             stall_ddr_cnt,
  output logic [31:0]             stall_rd_cnt
`endif
);

  state_t state;
  state_t nxt;

  logic [ADDR_LEN-1:0] nrows_q;
  logic [ADDR_LEN-1:0] nkset_q;
  logic [ADDR_LEN-1:0] kcnt;
  logic [ADDR_LEN-1:0] rd_ptr;
  logic                accept;
  logic                issue;
  logic                more;
  logic                fin;

  assign accept = (state == IDLE) && start;
  assign issue  = (state == RD_ISSUE) && buf_idle && kset_ready;
  assign more   = ({1'b0, kcnt} + (ADDR_LEN+1)'(1)) < {1'b0, nkset_q};
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  wsched_wr_seq #(
    .ADDR_LEN    (ADDR_LEN),
    .DATA_LEN    (DATA_LEN),
    .DDR_DATA_LEN(DDR_DATA_LEN),
    .BUFFER_NUM  (BUFFER_NUM)
  ) u_wr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .active   (state == LOAD),
    .base_addr(base_addr),
    .num_rows (nrows_q),
    .ddr_data (ddr_data),
    .ddr_valid(ddr_valid),
    .ddr_ready(ddr_ready),
    .data_wr  (data_wr),
    .wr_addr  (wr_addr),
    .wr_en    (wr_en),
    .fin      (fin)
  );

  // job sequencing; LOAD lingers one cycle so the last write lands first
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_rows != '0)
            nxt = LOAD;
          else if (num_kset != '0)
            nxt = RD_ISSUE;
          else
            nxt = DONE;
        end
      end
      LOAD: begin
        if (fin)
          nxt = (nkset_q != '0) ? RD_ISSUE : DONE;
      end
      RD_ISSUE: begin
        if (issue)
          nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (ker_en)
          nxt = more ? RD_ISSUE : DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  // job parameters and kernel-set read pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nrows_q <= '0;
      nkset_q <= '0;
      kcnt    <= '0;
      rd_ptr  <= '0;
    end else if (accept) begin
      nrows_q <= num_rows;
      nkset_q <= num_kset;
      kcnt    <= '0;
      rd_ptr  <= base_addr;
    end else if (state == RD_WAIT && ker_en) begin
      kcnt   <= kcnt + ADDR_LEN'(1);
      rd_ptr <= rd_ptr + ADDR_LEN'(KSET_ROWS);
    end
  end

  // single-cycle read launch with its start row
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_conf    <= 1'b0;
      st_rd_addr <= '0;
    end else begin
      rd_conf <= issue;
      if (issue)
        st_rd_addr <= rd_ptr;
    end
  end

`ifdef WSCHED_PERF_CNT_EN
  // saturating stall counters, cleared per job
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      stall_ddr_cnt <= '0;
      stall_rd_cnt  <= '0;
    end else begin
      if (state == LOAD && !ddr_valid && stall_ddr_cnt != '1)
        stall_ddr_cnt <= stall_ddr_cnt + 32'd1;
      if (state == RD_ISSUE && !issue && stall_rd_cnt != '1)
        stall_rd_cnt <= stall_rd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_buf_sched.sv
// Self-checking bench for weight_buf_sched.
// Directed jobs checked against a queue-based model of writes and reads.
module tb_weight_buf_sched;
  import wbuf_pkg::*;

  localparam int GRP = 8;
  localparam int KR  = 9;

  typedef struct packed {
    logic [15:0]  addr;
    logic [31:0]  en;
    logic [255:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [15:0]  num_rows = '0;
  logic [15:0]  num_kset = '0;
  logic [255:0] ddr_data = '0;
  logic         ddr_valid = 1'b0;
  logic         ddr_ready;
  logic [255:0] data_wr;
  logic [15:0]  wr_addr;
  logic [31:0]  wr_en;
  logic         rd_conf;
  logic [15:0]  st_rd_addr;
  logic         buf_idle = 1'b1;
  logic         ker_en = 1'b0;
  logic         kset_ready = 1'b1;
  logic         busy;
  logic         done;

  weight_buf_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .num_kset  (num_kset),
    .ddr_data  (ddr_data),
    .ddr_valid (ddr_valid),
    .ddr_ready (ddr_ready),
    .data_wr   (data_wr),
    .wr_addr   (wr_addr),
    .wr_en     (wr_en),
    .rd_conf   (rd_conf),
    .st_rd_addr(st_rd_addr),
    .buf_idle  (buf_idle),
    .ker_en    (ker_en),
    .kset_ready(kset_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];

  function automatic logic [255:0] pat(input int salt, input int i);
    logic [31:0] w;
    w = 32'(salt * 32'h01000193 + i * 32'h9E3779B9);
    return {8{w}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // spec-level write plan: beat i of the job -> row i/8, bank group i%8
  task automatic plan_load(input logic [15:0] b, input int salt,
                           input int limit);
    src_idx   = 0;
    src_salt  = salt;
    src_total = limit;
    for (int i = 0; i < limit; i++) begin
      wr_t w;
      w.addr = b + 16'(i / GRP);
      w.en   = 32'hF << (4 * (i % GRP));
      w.data = pat(salt, i);
      exp_wr.push_back(w);
    end
  endtask

  task automatic plan_read(input logic [15:0] b, input int n);
    for (int j = 0; j < n; j++)
      exp_rd.push_back(16'(b + j * KR));
  endtask

  // DDR source: one pattern word per accepted beat
  int src_idx = 0;
  int src_total = 0;
  int src_salt = 0;
  bit src_on = 1'b0;
  bit src_mode = 1'b0;
  bit src_tog = 1'b0;
  logic src_hs;
  always begin
    @(negedge clk);
    src_hs = ddr_valid && ddr_ready;
    @(posedge clk);
    #1;
    if (src_hs) src_idx++;
    if (src_on && src_idx < src_total) begin
      src_tog   = !src_tog;
      ddr_valid = src_mode ? src_tog : 1'b1;
      ddr_data  = pat(src_salt, src_idx);
    end else begin
      ddr_valid = 1'b0;
    end
  end

  // kernel-valid responder: ker_en 11 cycles after each rd_conf
  bit ker_auto = 1'b0;
  always begin
    @(negedge clk);
    if (rd_conf && ker_auto) begin
      repeat (11) @(posedge clk);
      #1 ker_en = 1'b1;
      @(posedge clk);
      #1 ker_en = 1'b0;
    end
  end

  // compare process
  logic prev_hs = 1'b0;
  logic rd_out = 1'b0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   first_hs = -1;
  wr_t  mon_e;
  always @(negedge clk) begin
    cyc++;
    if (prev_hs) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_extra actual=%0h required=none", wr_en);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_en", wr_en, mon_e.en);
        chk("wr_addr", wr_addr, mon_e.addr);
        chk("data_wr", data_wr, mon_e.data);
      end
    end else begin
      chk("wr_en_quiet", wr_en, 0);
    end
    prev_hs = ddr_valid && ddr_ready;
    if (prev_hs && first_hs < 0) first_hs = cyc;
    if (rd_conf) begin
      if (rd_out) begin
        checks++;
        errors++;
        $display("FAIL rd_overlap actual=1 required=0");
      end
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra actual=%0h required=none", st_rd_addr);
      end else begin
        chk("st_rd_addr", st_rd_addr, exp_rd.pop_front());
      end
      rd_out = 1'b1;
    end
    if (ker_en) rd_out = 1'b0;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic do_start(input logic [15:0] b, input logic [15:0] r,
                          input logic [15:0] k);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    num_rows  = r;
    num_kset  = k;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({nm, "_done_count"}, done_cnt - d0, 1);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_wr_left"}, exp_wr.size(), 0);
    chk({nm, "_rd_left"}, exp_rd.size(), 0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ddr_ready"}, ddr_ready, 0);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_rd_conf"}, rd_conf, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_data_wr"}, data_wr, 0);
    chk({nm, "_wr_addr"}, wr_addr, 0);
    chk({nm, "_st_rd_addr"}, st_rd_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // two-row load, valid always high
    plan_load(16'h0100, 1, 16);
    chk("pin_en0", exp_wr[0].en, 32'h0000000F);
    chk("pin_en15", exp_wr[15].en, 32'hF0000000);
    chk("pin_addr7", exp_wr[7].addr, 16'h0100);
    chk("pin_addr8", exp_wr[8].addr, 16'h0101);
    src_mode = 1'b0;
    first_hs = -1;
    src_on   = 1'b1;
    do_start(16'h0100, 16'd2, 16'd0);
    wait_done("load_v1", 100);
    chk("done_latency", done_cyc - first_hs, 17);
    src_on = 1'b0;

    // same job, valid toggling
    plan_load(16'h0100, 2, 16);
    src_mode = 1'b1;
    src_on   = 1'b1;
    do_start(16'h0100, 16'd2, 16'd0);
    wait_done("load_tog", 200);
    src_on   = 1'b0;
    src_mode = 1'b0;

    // three kernel sets with address wrap
    plan_read(16'hFFF8, 3);
    chk("pin_rd0", exp_rd[0], 16'hFFF8);
    chk("pin_rd1", exp_rd[1], 16'h0001);
    chk("pin_rd2", exp_rd[2], 16'h000A);
    ker_auto = 1'b1;
    do_start(16'hFFF8, 16'd0, 16'd3);
    wait_done("rd3", 200);

    // kset_ready held low for 20 cycles in RD_ISSUE
    kset_ready = 1'b0;
    do_start(16'h0040, 16'd0, 16'd1);
    repeat (20) @(posedge clk);
    plan_read(16'h0040, 1);
    #1 kset_ready = 1'b1;
    @(negedge clk);
    chk("rd_hold", rd_conf, 0);
    chk("busy_stall", busy, 1);
    @(negedge clk);
    chk("rd_issue_next", rd_conf, 1);
    wait_done("rd_stall", 100);

    // reset mid-load after beat 3
    plan_load(16'h0100, 3, 4);
    src_on = 1'b1;
    do_start(16'h0100, 16'd2, 16'd0);
    n = 0;
    while (src_idx < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_beats", src_idx, 4);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("mid_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_wr_left", exp_wr.size(), 0);

    // fresh job reloads from beat 0
    plan_load(16'h0200, 4, 8);
    do_start(16'h0200, 16'd1, 16'd0);
    wait_done("reload", 100);
    src_on = 1'b0;

    // start during RD_WAIT is ignored
    plan_read(16'h0010, 2);
    do_start(16'h0010, 16'd0, 16'd2);
    n = 0;
    while (!rd_conf && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rd_conf", rd_conf, 1);
    do_start(16'h5555, 16'd1, 16'd0);
    chk("busy_ignore", busy, 1);
    wait_done("busy_start", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_buf_sched.md
WEIGHT_BUF_SCHED -- requirements
Module: weight_buf_sched

Interface
REQ-001 Parameters SHALL be: ADDR_LEN, 16, buffer address width; DATA_LEN, 64, bank word width; DDR_DATA_LEN, 256, DDR beat width; BUFFER_NUM, 32, bank count; KSET_ROWS, 9, rows per kernel set.
REQ-002 Derived constant GRP_NUM = BUFFER_NUM/(DDR_DATA_LEN/DATA_LEN), default 8: beats per buffer row.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; begins a job; ignored unless busy=0.
REQ-006 base_addr  in  ADDR_LEN  first buffer row of the job; sampled on start.
REQ-007 num_rows  in  ADDR_LEN  rows to load, 0 = skip load; sampled on start.
REQ-008 num_kset  in  ADDR_LEN  kernel sets to read, 0 = skip read; sampled on start.
REQ-009 ddr_data / ddr_valid / ddr_ready  in / in / out  DDR_DATA_LEN / 1 / 1  weight beat stream.
REQ-010 data_wr / wr_addr / wr_en  out  DDR_DATA_LEN / ADDR_LEN / BUFFER_NUM  buffer write port.
REQ-011 rd_conf / st_rd_addr  out  1 / ADDR_LEN  buffer read launch.
REQ-012 buf_idle / ker_en  in  1 / 1  buffer status and kernel-valid strobe.
REQ-013 kset_ready  in  1  downstream PE array can accept the next kernel set.
REQ-014 busy / done  out  1 / 1  job active; one-cycle job-complete pulse.

Function
REQ-015 States SHALL be IDLE, LOAD, RD_ISSUE, RD_WAIT, DONE.
REQ-016 IDLE->LOAD on start with num_rows!=0; IDLE->RD_ISSUE on start with num_rows=0 and num_kset!=0; IDLE->DONE on start with both 0.
REQ-017 LOAD: ddr_ready=1; a beat transfers when ddr_valid&&ddr_ready.
REQ-018 Transferred beat g (0..GRP_NUM-1) of row r SHALL register: data_wr=ddr_data, wr_addr=base_addr+r, wr_en bits [g*4 +: 4] high, all other bits low; one-cycle latency.
REQ-019 wr_en SHALL be all-zero in any cycle following no transfer.
REQ-020 After beat GRP_NUM-1 of row num_rows-1, ddr_ready SHALL drop the next cycle; state -> RD_ISSUE (or DONE if num_kset=0).
REQ-021 RD_ISSUE: when buf_idle&&kset_ready, rd_conf=1 for exactly one cycle with st_rd_addr=base_addr+k*KSET_ROWS, k = current set index; -> RD_WAIT.
REQ-022 RD_WAIT: on ker_en, k increments; -> RD_ISSUE if k<num_kset, else DONE.
REQ-023 No second rd_conf SHALL issue before ker_en for the previous one.
REQ-024 DONE: done=1 for one cycle; -> IDLE.
REQ-025 busy=1 in every state except IDLE.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_LEN.
REQ-027 start while busy=1 SHALL be ignored with no state change.
REQ-028 ddr_valid with ddr_ready=0 SHALL not be consumed.
REQ-029 ker_en outside RD_WAIT SHALL be ignored.

Reset
REQ-030 With rst_n=0 at a clock edge: state=IDLE; ddr_ready, wr_en, rd_conf, busy, done=0; data_wr, wr_addr, st_rd_addr=0; counters=0.
REQ-031 Reset mid-job SHALL abandon the job; a half-written row is not completed.

Configuration
REQ-032 With WSCHED_PERF_CNT_EN defined: 32-bit outputs stall_ddr_cnt (LOAD cycles with ddr_valid=0) and stall_rd_cnt (RD_ISSUE cycles not issuing); both clear on start and on reset, and saturate at max.
REQ-033 Without WSCHED_PERF_CNT_EN: these ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-034 Package wbuf_pkg SHALL hold the state enum, GRP_NUM derivation, and the default ADDR_LEN/DATA_LEN/DDR_DATA_LEN/BUFFER_NUM constants.
REQ-035 Beat/row counting and wr_en decode SHALL be sub-module wsched_wr_seq; the read FSM stays in the top module.

Verification
REQ-036 start, base_addr=0x0100, num_rows=2, num_kset=0, ddr_valid always 1 -> 16 writes, wr_addr 0x0100 x8 then 0x0101 x8, wr_en 0x0000000F..0xF0000000 twice, done 17 cycles after the first transfer.
REQ-037 Same job, ddr_valid toggled every cycle -> identical write sequence, no beat dropped or duplicated.
REQ-038 num_rows=0, num_kset=3, base_addr=0xFFF8, buf_idle=kset_ready=1, ker_en 11 cycles after each rd_conf -> st_rd_addr 0xFFF8, 0x0001, 0x000A; one done.
REQ-039 kset_ready held 0 for 20 cycles in RD_ISSUE -> no rd_conf; issues the cycle after kset_ready rises; with WSCHED_PERF_CNT_EN, stall_rd_cnt=20.
REQ-040 rst_n=0 during LOAD after beat 3 -> all outputs at reset values next cycle; a new start reloads from beat 0.
REQ-041 start pulsed during RD_WAIT -> ignored; the original job completes unchanged.
